eth_rx_frame_filter: RTL and testbench
======================================

ETH_RX_FRAME_FILTER -- requirements
Module: eth_rx_frame_filter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, meaning log2 of buffer depth in 64-bit words (512 words = 4096 bytes).
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port async_resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports s_axis_tdata/tkeep/tlast/tuser/tvalid  input  64/8/1/1/1  MAC receive stream; tuser=1 on tlast beat marks a bad frame (FCS or PHY error).
REQ-005 SHALL have port s_axis_tready  output  1  buffer accepts a beat.
REQ-006 SHALL have ports m_axis_tdata/tkeep/tlast/tvalid  output  64/8/1/1  filtered stream toward the DMA core.
REQ-007 SHALL have port m_axis_tready  input  1  downstream accepts a beat.
REQ-008 SHALL have port mac_addr  input  48  station address; mac_addr[47:40] is the first byte on the wire.
REQ-009 SHALL have port promisc  input  1  accept every good frame regardless of destination.
REQ-010 SHALL have ports rx_frame_count and rx_drop_count  output  32  each  forwarded and dropped frame counters.

Function
REQ-011 SHALL be store-and-forward: no beat of a frame appears on m_axis before that frame's tlast beat has been accepted on s_axis and judged good.
REQ-012 SHALL hold s_axis_tready=1 at all times out of reset; the MAC cannot be backpressured, so all loss is by dropping.
REQ-013 SHALL store {tlast, tkeep, tdata} per accepted beat at write pointer wr_spec; committed pointer wr_ptr and read pointer rd_ptr are ADDR_BITS+1 bits and wrap modulo 2^(ADDR_BITS+1).
REQ-014 SHALL evaluate destination on the first beat of a frame: byte0 is tdata[7:0]. Match = promisc, OR bytes0-5 equal mac_addr, OR bytes0-5 all 0xFF, OR byte0 bit0 = 1 (multicast).
REQ-015 SHALL flag overflow when a beat arrives while wr_spec - rd_ptr == 2^ADDR_BITS; the beat is discarded and the flag holds until that frame's tlast.
REQ-016 On an accepted tlast beat, SHALL commit the frame when there is an address match, tuser=0 and no overflow; commit sets wr_ptr = wr_spec+1 and increments rx_frame_count.
REQ-017 On an accepted tlast beat that fails REQ-016, SHALL rewind wr_spec to wr_ptr in the same cycle and increment rx_drop_count.
REQ-018 SHALL treat a single-beat frame (tlast on first beat) under the same rules; the address check uses that beat.
REQ-019 SHALL implement the output as FIFO read plus one output register; m_axis_tvalid asserts when committed data exists (rd_ptr != wr_ptr) or the register is occupied.
REQ-020 Latency: tlast accepted at cycle N gives earliest m_axis_tvalid at N+2 when the output is empty.
REQ-021 SHALL sustain one beat per cycle on m_axis with m_axis_tready held high; data, tkeep and tlast are stable while tvalid=1 and tready=0.
REQ-022 SHALL allow commit, rewind and read in the same cycle without loss; a read never passes wr_ptr.
REQ-023 Counters SHALL wrap modulo 2^32.

Reset
REQ-024 While async_resetn=0: all pointers 0, overflow flag 0, in-frame state idle, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, counters 0.
REQ-025 Reset mid-frame SHALL discard all buffered and partial frames. The first beat after release is treated as a frame start.

Verification
REQ-026 mac_addr=02:00:00:00:00:01. Send a 3-beat frame to that address with tuser=0 -> same 3 beats out, with tkeep/tlast intact; rx_frame_count=1; first m_axis_tvalid 2 cycles after input tlast.
REQ-027 Send a frame to 02:00:00:00:00:02 with promisc=0 -> no output, rx_drop_count=1. Repeat with promisc=1 -> frame forwarded.
REQ-028 Send a matching frame with tuser=1 on tlast, then a good frame -> only the good frame emerges, with no stale beats; drop=1, frame=1.
REQ-029 ADDR_BITS=4, m_axis_tready=0: send a 10-beat good frame, then a 10-beat good frame -> second frame dropped (overflow). Then raise tready -> exactly the first 10 beats out.
REQ-030 Hold m_axis_tready random 50% across 20 back-to-back broadcast frames -> every frame is delivered in order, byte-exact, with no duplicates.
REQ-031 Assert async_resetn=0 mid-frame with 2 frames committed -> outputs are at reset values immediately; after release the output stays empty until a new good frame arrives.

Source files
------------

// File: rtl/eth_rx_frame_filter_if.sv
// AXI-Stream bundle for the receive filter: 64-bit data with byte keep, last and user flags.
interface eth_rx_frame_filter_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward Ethernet receive filter: buffers each frame speculatively and commits it
// only when its destination matches, the MAC reports it good and it fit in the buffer.
module eth_rx_frame_filter #(
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                  clock,
  input  logic                  async_resetn,
  eth_rx_frame_filter_if.slave  s_axis,
  eth_rx_frame_filter_if.master m_axis,
  input  logic [47:0]           mac_addr,
  input  logic                  promisc,
  output logic [31:0]           rx_frame_count,
  output logic [31:0]           rx_drop_count
);
  localparam int unsigned Depth = 2 ** ADDR_BITS;
  localparam int unsigned PtrW  = ADDR_BITS + 1;
  typedef logic [PtrW-1:0] ptr_t;

  typedef enum logic [0:0] {StIdle, StFrame} state_e;
  state_e state_q, state_d;

  logic [72:0] mem [Depth];
  ptr_t        wr_spec_q, wr_spec_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, used;
  logic        ovf_q, ovf_d, match_q, match_d, ready_q;
  logic [31:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic        out_valid_q;
  logic [72:0] out_q;
  logic        first_beat, beat, dest_match, match_now, ovf_now, wr_en, good, rd_en;
  logic [47:0] dest;

  assign beat = s_axis.tvalid & ready_q;
  // Byte 0 of the frame sits in tdata[7:0] and corresponds to mac_addr[47:40].
  assign dest = {s_axis.tdata[7:0],   s_axis.tdata[15:8],  s_axis.tdata[23:16],
                 s_axis.tdata[31:24], s_axis.tdata[39:32], s_axis.tdata[47:40]};
  assign dest_match = promisc | (dest == mac_addr) | (&dest) | dest[40];
  assign match_now  = first_beat ? dest_match : match_q;
  assign used       = wr_spec_q - rd_ptr_q;
  assign ovf_now    = ovf_q | (used == ptr_t'(Depth));
  assign wr_en      = beat & ~ovf_now;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) state_q <= StIdle;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (beat && !s_axis.tlast) state_d = StFrame;
      StFrame: if (beat && s_axis.tlast)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    first_beat = (state_q == StIdle);
  end

  always_comb begin
    wr_spec_d   = wr_spec_q;
    wr_ptr_d    = wr_ptr_q;
    ovf_d       = ovf_q;
    match_d     = match_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    good        = 1'b0;
    if (beat) begin
      if (s_axis.tlast) begin
        good  = match_now & ~s_axis.tuser & ~ovf_now;
        ovf_d = 1'b0;
        if (good) begin
          wr_spec_d   = wr_spec_q + ptr_t'(1);
          wr_ptr_d    = wr_spec_q + ptr_t'(1);
          frame_cnt_d = frame_cnt_q + 32'd1;
        end else begin
          wr_spec_d  = wr_ptr_q;
          drop_cnt_d = drop_cnt_q + 32'd1;
        end
      end else begin
        ovf_d   = ovf_now;
        match_d = match_now;
        if (!ovf_now) wr_spec_d = wr_spec_q + ptr_t'(1);
      end
    end
  end

  // Only committed entries are read, so a read never races the write of the same slot.
  assign rd_en    = (rd_ptr_q != wr_ptr_q) & (~out_valid_q | m_axis.tready);
  assign rd_ptr_d = rd_ptr_q + ptr_t'(rd_en);

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      wr_spec_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      match_q     <= 1'b0;
      ready_q     <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_spec_q   <= wr_spec_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      match_q     <= match_d;
      ready_q     <= 1'b1;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      if (rd_en) begin
        out_q       <= mem[rd_ptr_q[ADDR_BITS-1:0]];
        out_valid_q <= 1'b1;
      end else if (m_axis.tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_spec_q[ADDR_BITS-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  end

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_q[72];
  assign m_axis.tkeep  = out_q[71:64];
  assign m_axis.tdata  = out_q[63:0];
  assign m_axis.tuser  = 1'b0;
  assign rx_frame_count = frame_cnt_q;
  assign rx_drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Randomized scoreboard bench for eth_rx_frame_filter: a frame-level model predicts which frames
// survive, and monitors compare every delivered beat against the queued expectation.
module tb_eth_rx_frame_filter;
  localparam logic [47:0] Mac = 48'h02_00_00_00_00_01;
  typedef struct packed {logic last; logic [7:0] keep; logic [63:0] data;} beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0, tuser = 1'b0;
  logic        vld_big = 1'b0, vld_small = 1'b0, rdy_big = 1'b0, rdy_small = 1'b0;
  logic        rand_rdy = 1'b0, promisc = 1'b0;
  logic [47:0] mac = Mac;
  logic [31:0] fc_big, dc_big, fc_small, dc_small;
  int unsigned cyc = 0, n_chk = 0, n_fail = 0;
  int unsigned exp_fc_big = 0, exp_dc_big = 0, exp_fc_small = 0, exp_dc_small = 0;
  int unsigned seen_big = 0, seen_small = 0, occ_small = 0;
  beat_t exp_big[$], exp_small[$];
  logic  stall_big = 1'b0;
  beat_t held_big;

  eth_rx_frame_filter_if s_big ();
  eth_rx_frame_filter_if m_big ();
  eth_rx_frame_filter_if s_small ();
  eth_rx_frame_filter_if m_small ();

  assign s_big.tdata    = tdata;
  assign s_big.tkeep    = tkeep;
  assign s_big.tlast    = tlast;
  assign s_big.tuser    = tuser;
  assign s_big.tvalid   = vld_big;
  assign m_big.tready   = rdy_big;
  assign s_small.tdata  = tdata;
  assign s_small.tkeep  = tkeep;
  assign s_small.tlast  = tlast;
  assign s_small.tuser  = tuser;
  assign s_small.tvalid = vld_small;
  assign m_small.tready = rdy_small;

  eth_rx_frame_filter dut_big (
    .clock(clk), .async_resetn(rst_n), .s_axis(s_big), .m_axis(m_big),
    .mac_addr(mac), .promisc(promisc), .rx_frame_count(fc_big), .rx_drop_count(dc_big)
  );

  eth_rx_frame_filter #(.ADDR_BITS(4)) dut_small (
    .clock(clk), .async_resetn(rst_n), .s_axis(s_small), .m_axis(m_small),
    .mac_addr(mac), .promisc(promisc), .rx_frame_count(fc_small), .rx_drop_count(dc_small)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rand_rdy) begin #1; rdy_big = 1'($urandom_range(0, 1)); end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    beat_t got, e;
    if (!rst_n) stall_big = 1'b0;
    else begin
      got = {m_big.tlast, m_big.tkeep, m_big.tdata};
      if (stall_big) check("stall_hold", {m_big.tvalid, got}, {1'b1, held_big});
      if (m_big.tvalid && rdy_big) begin
        seen_big++;
        if (exp_big.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat_big: got %0h, expected no beat", got);
        end else begin
          e = exp_big.pop_front();
          check("beat_big", got, e);
        end
      end
      stall_big = m_big.tvalid && !rdy_big;
      held_big  = got;
    end
  end

  always @(negedge clk) begin
    beat_t got, e;
    if (rst_n && m_small.tvalid && rdy_small) begin
      got = {m_small.tlast, m_small.tkeep, m_small.tdata};
      seen_small++;
      if (exp_small.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat_small: got %0h, expected no beat", got);
      end else begin
        e = exp_small.pop_front();
        check("beat_small", got, e);
      end
    end
  end

  // Drives one frame back-to-back; the model decides its fate from the filtering rules.
  task automatic send(input bit big, input logic [47:0] dest, input int len, input bit bad);
    beat_t b[$];
    bit keep_it;
    check(big ? "s_ready_big" : "s_ready_small",
          big ? s_big.tready : s_small.tready, 1);
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.data = {$urandom, $urandom};
      if (i == 0) x.data[47:0] = {dest[7:0], dest[15:8], dest[23:16], dest[31:24],
                                  dest[39:32], dest[47:40]};
      x.last = (i == len - 1);
      x.keep = x.last ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF;
      b.push_back(x);
    end
    keep_it = !bad && (promisc || dest == mac || dest == 48'hFFFF_FFFF_FFFF || dest[40]);
    // With the small buffer stalled, anything beyond its 16 words cannot be held.
    if (!big && occ_small + len > 16) keep_it = 1'b0;
    foreach (b[i]) begin
      @(posedge clk); #1;
      tdata = b[i].data; tkeep = b[i].keep; tlast = b[i].last;
      tuser = b[i].last ? bad : 1'($urandom_range(0, 1));
      vld_big = big; vld_small = !big;
    end
    if (keep_it) begin
      foreach (b[i]) if (big) exp_big.push_back(b[i]); else exp_small.push_back(b[i]);
      if (big) exp_fc_big++; else begin exp_fc_small++; occ_small += len; end
    end else if (big) exp_dc_big++;
    else exp_dc_small++;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    vld_big = 1'b0; vld_small = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic drain(input bit big);
    int t = 0;
    while ((big ? exp_big.size() : exp_small.size()) != 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    repeat (4) @(negedge clk);
    check(big ? "drain_big" : "drain_small", big ? exp_big.size() : exp_small.size(), 0);
  endtask

  task automatic check_counts();
    check("frame_count_big", fc_big, exp_fc_big);
    check("drop_count_big", dc_big, exp_dc_big);
  endtask

  initial begin
    int unsigned t0, lat, seen0;
    logic [47:0] dests [5];
    dests[0] = Mac; dests[1] = 48'h02_00_00_00_00_02; dests[2] = 48'h01_00_5E_00_00_01;
    dests[3] = 48'hFFFF_FFFF_FFFF; dests[4] = 48'h0;

    #12;
    check("rst_s_ready", s_big.tready, 0);
    check("rst_m_valid", {m_big.tvalid, m_small.tvalid}, 0);
    check("rst_m_data", {m_big.tlast, m_big.tkeep, m_big.tdata}, 0);
    check("rst_counts", {fc_big, dc_big, fc_small, dc_small}, 0);
    @(negedge clk) rst_n = 1'b1;
    rdy_big = 1'b1;
    repeat (3) @(negedge clk);

    // Unicast to our address, with latency measured from tlast acceptance.
    send(1, Mac, 3, 0);
    idle();
    t0 = cyc; lat = 99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_big.tvalid) begin lat = cyc + 1 - t0; break; end
    end
    check("latency", lat, 2);
    drain(1); check_counts();

    send(1, 48'h02_00_00_00_00_02, 4, 0); idle();
    drain(1); check_counts();
    promisc = 1'b1;
    send(1, 48'h02_00_00_00_00_02, 4, 0); idle();
    promisc = 1'b0;
    drain(1); check_counts();

    send(1, Mac, 5, 1);
    send(1, Mac, 2, 0); idle();
    drain(1); check_counts();

    for (int f = 0; f < 24; f++) begin
      logic [47:0] d;
      d = dests[$urandom_range(0, 4)];
      if (d == 48'h0) d = {$urandom, 16'($urandom)};
      promisc = ($urandom_range(0, 3) == 0);
      send(1, d, $urandom_range(1, 6), $urandom_range(0, 3) == 0);
    end
    idle(); promisc = 1'b0;
    drain(1); check_counts();

    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) send(1, 48'hFFFF_FFFF_FFFF, $urandom_range(1, 8), 0);
    idle();
    drain(1); check_counts();
    rand_rdy = 1'b0;
    @(posedge clk); #2 rdy_big = 1'b1;

    // Small buffer with output stalled: second frame cannot fit.
    rdy_small = 1'b0;
    send(0, Mac, 10, 0);
    send(0, Mac, 10, 0); idle();
    repeat (5) @(negedge clk);
    check("small_frame_count", fc_small, exp_fc_small);
    check("small_drop_count", dc_small, exp_dc_small);
    check("small_no_output", seen_small, 0);
    rdy_small = 1'b1;
    drain(0);
    check("small_beats_out", seen_small, 10);

    // Reset mid-frame with two committed frames held back.
    rdy_big = 1'b0;
    send(1, Mac, 3, 0);
    send(1, Mac, 2, 0); idle();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tdata = {$urandom, 32'hFFFF_FFFF}; tkeep = 8'hFF; tlast = 1'b0; vld_big = 1'b1;
    end
    @(negedge clk) rst_n = 1'b0;
    vld_big = 1'b0;
    #1;
    check("mid_rst_m_valid", m_big.tvalid, 0);
    check("mid_rst_m_data", {m_big.tlast, m_big.tkeep, m_big.tdata}, 0);
    check("mid_rst_s_ready", s_big.tready, 0);
    check("mid_rst_counts", {fc_big, dc_big}, 0);
    exp_big.delete(); exp_small.delete();
    exp_fc_big = 0; exp_dc_big = 0; occ_small = 0;
    @(negedge clk) rst_n = 1'b1;
    rdy_big = 1'b1;
    seen0 = seen_big;
    repeat (20) @(negedge clk);
    check("post_rst_empty", seen_big - seen0, 0);
    send(1, Mac, 3, 0); idle();
    drain(1); check_counts();
    check("post_rst_beats", seen_big - seen0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end
endmodule
